// File: rtl/mig_bus_arbiter.sv
// mig_bus_arbiter: registered N-to-1 arbiter merging native MIG-width master buses onto the L2 cache bus.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-low reset
//   m_req  - N_MASTERS packed requests, slice i = {valid, addr, wdata, wstrb}
//   m_resp - N_MASTERS packed responses, slice i = {rdata, ready}
//   s_req  - request to the L2 cache, same packing as one m_req slice
//   s_resp - response from the L2 cache, same packing as one m_resp slice
//   busy   - high while a grant is held
//
// Build option: define MIG_ARB_FIXED_PRIO_EN for fixed priority (highest index wins)
// instead of round-robin; everything else is identical.
module mig_bus_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    localparam int REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int RESP_W   = DATA_W + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*REQ_W-1:0]  m_req,
    output logic [N_MASTERS*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]            s_req,
    input  logic [RESP_W-1:0]           s_resp,
    output logic                        busy
);
    localparam int GW = $clog2(N_MASTERS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d, sel;
    logic [N_MASTERS-1:0] valid;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_port
        assign valid[i] = m_req[i*REQ_W + REQ_W - 1];
        assign m_resp[i*RESP_W +: RESP_W] = (busy && grant_q == GW'(i)) ? s_resp : '0;
    end

`ifdef MIG_ARB_FIXED_PRIO_EN
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_MASTERS; i++)
            if (valid[i]) sel = GW'(i);
    end
`else
    logic [GW-1:0] last_q;

    // Scan from farthest to nearest so the nearest valid index after last_q wins.
    always_comb begin
        sel = '0;
        for (int k = N_MASTERS; k >= 1; k--)
            if (valid[GW'((int'(last_q) + k) % N_MASTERS)])
                sel = GW'((int'(last_q) + k) % N_MASTERS);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            last_q <= GW'(N_MASTERS - 1);
        else if (state_q == IDLE && |valid)
            last_q <= sel;
`endif

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end

    // Granted master dropping valid before ready is an abort: release without a response.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: if (|valid) begin
                state_d = BUSY;
                grant_d = sel;
            end
            BUSY: if (!valid[grant_q] || s_resp[0]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy  = state_q == BUSY;
    assign s_req = busy ? m_req[int'(grant_q)*REQ_W +: REQ_W] : '0;
endmodule

// File: tb/tb_mig_bus_arbiter.sv
// tb_mig_bus_arbiter: directed self-checking bench for mig_bus_arbiter.
module tb_mig_bus_arbiter;
    localparam int N      = 4;
    localparam int AW     = 32;
    localparam int DW     = 256;
    localparam int REQ_W  = 1 + AW + DW + DW / 8;
    localparam int RESP_W = DW + 1;
    localparam int CW     = 1100;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N*REQ_W-1:0]     m_req;
    logic [N*RESP_W-1:0]    m_resp;
    logic [REQ_W-1:0]       s_req;
    logic [RESP_W-1:0]      s_resp;
    logic                   busy;
    logic                   mv [N];
    logic [AW-1:0]          ma [N];
    logic [DW-1:0]          mw [N];
    logic [DW/8-1:0]        ms [N];
    logic                   s_ready;
    logic [DW-1:0]          s_rdata;
    int                     checks = 0;
    int                     errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_req
        assign m_req[g*REQ_W +: REQ_W] = {mv[g], ma[g], mw[g], ms[g]};
    end
    assign s_resp = {s_rdata, s_ready};

    mig_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp),
        .s_req(s_req), .s_resp(s_resp), .busy(busy)
    );

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] req(input logic [AW-1:0] a, input logic [DW-1:0] w, input logic [DW/8-1:0] s);
        return CW'({1'b1, a, w, s});
    endfunction

    function automatic logic [CW-1:0] rsp(input int m, input logic [DW-1:0] d);
        return CW'({d, 1'b1}) << (m * RESP_W);
    endfunction

    task automatic idle_chk(input string tag);
        check({tag, ".busy"}, CW'(busy), CW'(0));
        check({tag, ".s_req"}, CW'(s_req), CW'(0));
        check({tag, ".m_resp"}, CW'(m_resp), CW'(0));
    endtask

    task automatic clear();
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0;
            ma[i] = '0;
            mw[i] = '0;
            ms[i] = '0;
        end
        s_ready = 1'b0;
        s_rdata = '0;
    endtask

    initial begin
        int ord [5] = '{0, 1, 2, 3, 0};
        clear();
        #2 rst = 1'b0;
        #1 idle_chk("rst");
        @(negedge clk) rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1 idle_chk($sformatf("idle%0d", c));
        end

        // single read from master 2, L2 answers in the fourth BUSY cycle
        @(negedge clk);
        mv[2] = 1'b1;
        ma[2] = 32'h40;
        #1 check("rd.t_busy", CW'(busy), CW'(0));
        @(negedge clk);
        #1 check("rd.busy", CW'(busy), CW'(1));
        check("rd.s_req", CW'(s_req), req(32'h40, '0, '0));
        check("rd.noready", CW'(m_resp), CW'(0));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1 check($sformatf("rd.wait%0d", c), CW'(m_resp), CW'(0));
        end
        @(negedge clk);
        s_ready = 1'b1;
        s_rdata = {32{8'hA5}};
        #1 check("rd.resp", CW'(m_resp), rsp(2, {32{8'hA5}}));
        check("rd.s_req2", CW'(s_req), req(32'h40, '0, '0));
        @(negedge clk);
        clear();
        #1 idle_chk("rd.after");

        @(negedge clk) rst = 1'b0;
        #1 idle_chk("rst2");
        @(negedge clk) rst = 1'b1;

`ifndef MIG_ARB_FIXED_PRIO_EN
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b1;
            ma[i] = AW'(32'h100 + i);
        end
        s_ready = 1'b1;
        #1 check("rr.t", CW'(busy), CW'(0));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (k % 2 == 0) begin
                check($sformatf("rr.req%0d", k), CW'(s_req), req(AW'(32'h100 + ord[k/2]), '0, '0));
                check($sformatf("rr.resp%0d", k), CW'(m_resp), rsp(ord[k/2], '0));
            end else
                check($sformatf("rr.gap%0d", k), CW'(busy), CW'(0));
        end
        clear();
`else
        @(negedge clk);
        mv[0] = 1'b1;
        ma[0] = 32'h10;
        mv[3] = 1'b1;
        ma[3] = 32'h13;
        s_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (k % 2 == 0) begin
                check($sformatf("fp.req%0d", k), CW'(s_req), req(32'h13, '0, '0));
                check($sformatf("fp.resp%0d", k), CW'(m_resp), rsp(3, '0));
            end else
                check($sformatf("fp.gap%0d", k), CW'(busy), CW'(0));
        end
        clear();
`endif
        @(negedge clk);
        #1 idle_chk("mid");

        // write passthrough from master 1
        @(negedge clk);
        mv[1] = 1'b1;
        ma[1] = 32'h80;
        mw[1] = {8{32'h12345678}};
        ms[1] = '1;
        #1 check("wr.t_busy", CW'(busy), CW'(0));
        @(negedge clk);
        #1 check("wr.s_req", CW'(s_req), req(32'h80, {8{32'h12345678}}, 32'hFFFFFFFF));
        check("wr.noready", CW'(m_resp), CW'(0));
        @(negedge clk);
        s_ready = 1'b1;
        #1 check("wr.s_req2", CW'(s_req), req(32'h80, {8{32'h12345678}}, 32'hFFFFFFFF));
        check("wr.resp", CW'(m_resp), rsp(1, '0));
        @(negedge clk);
        clear();
        #1 idle_chk("wr.after");

        // abort: master 3 drops valid before ready
        @(negedge clk);
        mv[3] = 1'b1;
        ma[3] = 32'hC0;
        @(negedge clk);
        #1 check("ab.busy", CW'(busy), CW'(1));
        check("ab.s_req", CW'(s_req), req(32'hC0, '0, '0));
        @(negedge clk);
        mv[3] = 1'b0;
        #1 check("ab.noready", CW'(m_resp), CW'(0));
        @(negedge clk);
        #1 idle_chk("ab.after");

        // reset asserted mid-transaction
        @(negedge clk);
        mv[0] = 1'b1;
        ma[0] = 32'h200;
        @(negedge clk);
        s_ready = 1'b1;
        #1 check("rs.pre", CW'(m_resp), rsp(0, '0));
        rst = 1'b0;
        #1 idle_chk("rs.mid");
        @(negedge clk);
        rst = 1'b1;
        clear();
        #1 idle_chk("rs.after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
